// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg : shared encodings for the accumulator CPU core                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_HALT  = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3,
    OP_CLEAR = 4'h4,
    OP_SKIP  = 4'h5,
    OP_JUMP  = 4'h6,
    OP_SUB   = 4'h7,
    OP_AND   = 4'h8,
    OP_OR    = 4'h9,
    OP_NOT   = 4'hA
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_INDIR  = 3'd2,
    S_OPREAD = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_NOT  = 3'd5
  } alu_sel_e;

  localparam logic [1:0] c_skip_lt    = 2'b00;
  localparam logic [1:0] c_skip_eq    = 2'b01;
  localparam logic [1:0] c_skip_gt    = 2'b10;
  localparam logic [1:0] c_skip_never = 2'b11;

  // Opcodes for which the indirect bit selects a pointer lookup.
  function automatic logic ind_honoured(input logic [3:0] op);
    case (op)
      OP_ADD, OP_LOAD, OP_STORE, OP_SUB,
      OP_AND, OP_OR, OP_JUMP:           return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic alu_sel_e alu_sel_for(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_alu : combinational accumulator ALU (pass/add/sub/and/or/not)          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            sel,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  import cpu_pkg::*;

  always_comb begin
    y = b;
    case (sel)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOT: y = ~a;
      default: y = b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/acc_cpu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_cpu_core : multi-cycle accumulator CPU with req/ready memory port      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module acc_cpu_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int RESET_PC   = 'h100,
  parameter int PC_STEP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic                  halted,
  output logic                  retire,
  output logic                  illegal
);
  import cpu_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] c_reset_pc = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] c_pc_step  = ADDR_WIDTH'(PC_STEP);

  state_e                r_state;
  state_e                w_next_state;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] r_mbr;
  logic [DATA_WIDTH-1:0] r_ac;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_ea;

  logic [DATA_WIDTH-1:0] w_ac_d;
  logic [ADDR_WIDTH-1:0] w_pc_d;
  logic [ADDR_WIDTH-1:0] w_ea_d;
  logic [DATA_WIDTH-1:0] w_alu_y;
  alu_sel_e              w_alu_sel;
  logic                  w_hs;
  logic                  w_ind;
  logic                  w_ind_eff;
  logic [3:0]            w_opcode;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [1:0]            w_skip_cond;
  logic                  w_skip_take;
  logic                  w_illegal_op;
  logic                  w_next_mem;
  logic                  w_retire_d;
  logic                  w_illegal_d;
  logic                  w_ir_unused;

  assign w_hs         = mem_req & mem_ready;
  assign w_ind        = r_ir[DATA_WIDTH-1];
  assign w_opcode     = r_ir[DATA_WIDTH-2 -: 4];
  assign w_addr       = r_ir[ADDR_WIDTH-1:0];
  assign w_skip_cond  = r_ir[11:10];
  assign w_ind_eff    = w_ind & ind_honoured(w_opcode);
  assign w_illegal_op = (w_opcode > 4'hA);
  assign w_ir_unused  = ^r_ir;

  assign pc = r_pc;
  assign ac = r_ac;

  always_comb begin
    w_skip_take = 1'b0;
    case (w_skip_cond)
      c_skip_lt: w_skip_take = r_ac[DATA_WIDTH-1];
      c_skip_eq: w_skip_take = (r_ac == '0);
      c_skip_gt: w_skip_take = !r_ac[DATA_WIDTH-1] && (r_ac != '0);
      default:   w_skip_take = 1'b0;
    endcase
  end

  cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .sel(w_alu_sel),
    .a  (r_ac),
    .b  (r_mbr),
    .y  (w_alu_y)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_hs) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        if (w_opcode == OP_HALT) begin
          w_next_state = S_HALT;
        end else if (w_ind_eff) begin
          w_next_state = S_INDIR;
        end else begin
          case (w_opcode)
            OP_ADD, OP_LOAD, OP_SUB,
            OP_AND, OP_OR:          w_next_state = S_OPREAD;
            OP_STORE:               w_next_state = S_WRITE;
            default:                w_next_state = S_FETCH;
          endcase
        end
      end
      S_INDIR: begin
        if (w_hs) begin
          if (w_opcode == OP_JUMP)       w_next_state = S_FETCH;
          else if (w_opcode == OP_STORE) w_next_state = S_WRITE;
          else                           w_next_state = S_OPREAD;
        end
      end
      S_OPREAD: begin
        if (w_hs) w_next_state = S_EXEC;
      end
      S_EXEC:  w_next_state = S_FETCH;
      S_WRITE: begin
        if (w_hs) w_next_state = S_FETCH;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    halted      = (r_state == S_HALT);
    w_alu_sel   = alu_sel_for(w_opcode);
    w_next_mem  = (w_next_state == S_FETCH) || (w_next_state == S_INDIR) ||
                  (w_next_state == S_OPREAD) || (w_next_state == S_WRITE);
    w_illegal_d = (r_state == S_DECODE) && w_illegal_op;
    w_retire_d  = 1'b0;
    case (r_state)
      S_DECODE: w_retire_d = (w_next_state == S_FETCH) || (w_next_state == S_HALT);
      S_INDIR:  w_retire_d = w_hs && (w_opcode == OP_JUMP);
      S_EXEC:   w_retire_d = 1'b1;
      S_WRITE:  w_retire_d = w_hs;
      default:  w_retire_d = 1'b0;
    endcase
  end

  // Architectural next values; DECODE preloads EA so INDIR reads at the IR address.
  always_comb begin
    w_pc_d = r_pc;
    w_ea_d = r_ea;
    w_ac_d = r_ac;
    case (r_state)
      S_FETCH: begin
        if (w_hs) w_pc_d = r_pc + c_pc_step;
      end
      S_DECODE: begin
        w_ea_d = w_addr;
        case (w_opcode)
          OP_CLEAR: w_ac_d = '0;
          OP_NOT:   w_ac_d = w_alu_y;
          OP_SKIP:  if (w_skip_take) w_pc_d = r_pc + c_pc_step;
          OP_JUMP:  if (!w_ind) w_pc_d = w_addr;
          default:  w_ac_d = r_ac;
        endcase
      end
      S_INDIR: begin
        if (w_hs) begin
          w_ea_d = mem_rdata[ADDR_WIDTH-1:0];
          if (w_opcode == OP_JUMP) w_pc_d = mem_rdata[ADDR_WIDTH-1:0];
        end
      end
      S_EXEC:  w_ac_d = w_alu_y;
      default: w_ac_d = r_ac;
    endcase
  end

  // Datapath and registered memory request; request fields only move at a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= c_reset_pc;
      r_ea      <= '0;
      r_ac      <= '0;
      r_ir      <= '0;
      r_mbr     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      r_pc    <= w_pc_d;
      r_ea    <= w_ea_d;
      r_ac    <= w_ac_d;
      retire  <= w_retire_d;
      illegal <= w_illegal_d;
      if ((r_state == S_FETCH) && w_hs)  r_ir  <= mem_rdata;
      if ((r_state == S_OPREAD) && w_hs) r_mbr <= mem_rdata;
      mem_req <= w_next_mem;
      mem_we  <= (w_next_state == S_WRITE);
      if (w_next_mem) mem_addr <= (w_next_state == S_FETCH) ? w_pc_d : w_ea_d;
      if (w_next_state == S_WRITE) mem_wdata <= w_ac_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_acc_cpu_core : directed program vectors and corner sequences            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_acc_cpu_core;

  localparam int DW = 32;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready = 1'b1;
  logic [AW-1:0] pc;
  logic [DW-1:0] ac;
  logic          halted;
  logic          retire;
  logic          illegal;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;
  int stall_addr = -1;
  int stall_left = 0;
  int retire_cnt = 0;
  int illegal_cnt = 0;
  int orphan_ill = 0;

  typedef struct {
    string              name;
    logic [0:5][31:0]   prog;
    logic [0:2][13:0]   da;
    logic [0:2][31:0]   dv;
    logic [31:0]        exp_ac;
    logic [13:0]        exp_pc;
    int                 exp_ret;
    int                 exp_ill;
    logic [13:0]        chk_a;
    logic [31:0]        chk_v;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  acc_cpu_core #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESET_PC  ('h100),
    .PC_STEP   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc       (pc),
    .ac       (ac),
    .halted   (halted),
    .retire   (retire),
    .illegal  (illegal)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_req && int'(mem_addr) == stall_addr && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else begin
      mem_ready = 1'b1;
    end
    if (retire) retire_cnt++;
    if (illegal) illegal_cnt++;
    if (illegal && !retire) orphan_ill++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [0:5][31:0] p, input logic [0:2][13:0] a,
                     input logic [0:2][31:0] d, input logic [31:0] eac, input logic [13:0] epc,
                     input int er, input int ei, input logic [13:0] ca, input logic [31:0] cv);
    vec_t v;
    v.name = nm; v.prog = p; v.da = a; v.dv = d;
    v.exp_ac = eac; v.exp_pc = epc; v.exp_ret = er; v.exp_ill = ei;
    v.chk_a = ca; v.chk_v = cv;
    vecs.push_back(v);
  endtask

  // Leaves the core held in reset with memory cleared and stalls disabled.
  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall_addr = -1;
    stall_left = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    @(negedge clk);
    retire_cnt = 0;
    illegal_cnt = 0;
    orphan_ill = 0;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 6; i++) mem[14'h100 + 14'(2 * i)] = v.prog[i];
    for (int i = 0; i < 3; i++) if (v.da[i] != 14'h0) mem[v.da[i]] = v.dv[i];
  endtask

  task automatic wait_halt(input string nm);
    int n;
    n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int req_seen;
    enter_reset();
    load(v);
    rst_n = 1'b1;
    wait_halt(v.name);
    req_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    chk({v.name, " ac"}, ac, v.exp_ac);
    chk({v.name, " pc"}, {18'd0, pc}, {18'd0, v.exp_pc});
    chk({v.name, " retires"}, retire_cnt, v.exp_ret);
    chk({v.name, " illegals"}, illegal_cnt, v.exp_ill);
    chk({v.name, " illegal w/o retire"}, orphan_ill, 32'd0);
    chk({v.name, " req after halt"}, req_seen, 32'd0);
    chk({v.name, " mem"}, mem[v.chk_a], v.chk_v);
  endtask

  initial begin
    int n;
    int occ;
    int bad_we;
    bit seen_we;

    add("basic",     {32'h10000120, 32'h00000122, 32'h18000124, 32'h08000000, 32'h0, 32'h0},
        {14'h120, 14'h122, 14'h0}, {32'd5, 32'd7, 32'd0}, 32'd12, 14'h108, 4, 0, 14'h124, 32'd12);
    add("ind_load",  {32'h90000130, 32'h08000000, 32'h0, 32'h0, 32'h0, 32'h0},
        {14'h130, 14'h140, 14'h0}, {32'h140, 32'd9, 32'd0}, 32'd9, 14'h104, 2, 0, 14'h140, 32'd9);
    add("skip_eq_t", {32'h20000000, 32'h28000400, 32'h50000000, 32'h08000000, 32'h0, 32'h0},
        {14'h0, 14'h0, 14'h0}, {32'd0, 32'd0, 32'd0}, 32'd0, 14'h108, 3, 0, 14'h104, 32'h50000000);
    add("skip_eq_n", {32'h10000120, 32'h28000400, 32'h50000000, 32'h08000000, 32'h0, 32'h0},
        {14'h120, 14'h0, 14'h0}, {32'd1, 32'd0, 32'd0}, 32'hFFFFFFFE, 14'h108, 4, 0, 14'h120, 32'd1);
    add("skip_lt",   {32'h20000000, 32'h50000000, 32'h28000000, 32'h50000000, 32'h08000000, 32'h0},
        {14'h0, 14'h0, 14'h0}, {32'd0, 32'd0, 32'd0}, 32'hFFFFFFFF, 14'h10A, 4, 0, 14'h0, 32'd0);
    add("skip_gt",   {32'h10000120, 32'h28000800, 32'h50000000, 32'h08000000, 32'h0, 32'h0},
        {14'h120, 14'h0, 14'h0}, {32'd1, 32'd0, 32'd0}, 32'd1, 14'h108, 3, 0, 14'h0, 32'd0);
    add("skip_never",{32'h20000000, 32'h28000C00, 32'h50000000, 32'h08000000, 32'h0, 32'h0},
        {14'h0, 14'h0, 14'h0}, {32'd0, 32'd0, 32'd0}, 32'hFFFFFFFF, 14'h108, 4, 0, 14'h0, 32'd0);
    add("sub_wrap",  {32'h20000000, 32'h38000120, 32'h08000000, 32'h0, 32'h0, 32'h0},
        {14'h120, 14'h0, 14'h0}, {32'd1, 32'd0, 32'd0}, 32'hFFFFFFFF, 14'h106, 3, 0, 14'h0, 32'd0);
    add("illegal",   {32'h58000000, 32'h08000000, 32'h0, 32'h0, 32'h0, 32'h0},
        {14'h0, 14'h0, 14'h0}, {32'd0, 32'd0, 32'd0}, 32'd0, 14'h104, 2, 1, 14'h0, 32'd0);
    add("and_or",    {32'h10000120, 32'h40000122, 32'h48000124, 32'h08000000, 32'h0, 32'h0},
        {14'h120, 14'h122, 14'h124}, {32'hF0F0, 32'hFF00, 32'h000F}, 32'hF00F, 14'h108, 4, 0, 14'h0, 32'd0);
    add("jump",      {32'h30000110, 32'h50000000, 32'h08000000, 32'h0, 32'h0, 32'h0},
        {14'h110, 14'h0, 14'h0}, {32'h08000000, 32'd0, 32'd0}, 32'd0, 14'h112, 2, 0, 14'h0, 32'd0);
    add("jump_ind",  {32'hB0000130, 32'h50000000, 32'h0, 32'h0, 32'h0, 32'h0},
        {14'h130, 14'h114, 14'h0}, {32'h114, 32'h08000000, 32'd0}, 32'd0, 14'h116, 2, 0, 14'h0, 32'd0);
    add("store_ind", {32'h10000120, 32'h98000130, 32'h08000000, 32'h0, 32'h0, 32'h0},
        {14'h120, 14'h130, 14'h0}, {32'd33, 32'h150, 32'd0}, 32'd33, 14'h106, 3, 0, 14'h150, 32'd33);
    add("ind_ignored",{32'hD8000000, 32'h88000000, 32'h0, 32'h0, 32'h0, 32'h0},
        {14'h0, 14'h0, 14'h0}, {32'd0, 32'd0, 32'd0}, 32'd0, 14'h104, 2, 1, 14'h0, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset values while held, after a run left non-zero state behind.
    enter_reset();
    chk("rst pc", {18'd0, pc}, 32'h100);
    chk("rst ac", ac, 32'd0);
    chk("rst strobes", {27'd0, mem_req, mem_we, halted, retire, illegal}, 32'd0);
    chk("rst addr", {18'd0, mem_addr}, 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);

    // First fetch request one cycle after release, then indirect LOAD latency of 5.
    mem[14'h100] = 32'h90000130; mem[14'h102] = 32'h08000000;
    mem[14'h130] = 32'h140;      mem[14'h140] = 32'd9;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first fetch", {29'd0, mem_req, mem_we, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
    chk("first addr", {18'd0, mem_addr}, 32'h100);
    n = 1;
    while (!retire && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ind load latency", n, 32'd6);

    // ADD with three wait states on its operand read.
    enter_reset();
    mem[14'h100] = 32'h00000120; mem[14'h102] = 32'h08000000; mem[14'h120] = 32'd4;
    stall_addr = 'h120;
    stall_left = 3;
    rst_n = 1'b1;
    n = 0; occ = 0; bad_we = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_req && mem_addr == 14'h120) begin
        occ++;
        if (mem_we) bad_we++;
      end
    end while (!retire && n < 50);
    chk("wait add latency", n, 32'd8);
    chk("wait req held", occ, 32'd4);
    chk("wait req we", bad_we, 32'd0);
    chk("wait add ac", ac, 32'd4);

    // Reset landing in the middle of a stalled STORE.
    enter_reset();
    mem[14'h100] = 32'h18000124; mem[14'h102] = 32'h08000000; mem[14'h124] = 32'hDEADBEEF;
    stall_addr = 'h124;
    stall_left = 5;
    rst_n = 1'b1;
    n = 0; seen_we = 0;
    while (!seen_we && n < 20) begin
      @(negedge clk);
      n++;
      seen_we = mem_req && mem_we;
    end
    chk("write reached", {31'd0, seen_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async req drop", {31'd0, mem_req}, 32'd0);
    chk("aborted write", mem[14'h124], 32'hDEADBEEF);
    chk("abort pc", {18'd0, pc}, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("refetch", {30'd0, mem_req, mem_we}, 32'd2);
    chk("refetch addr", {18'd0, mem_addr}, 32'h100);
    wait_halt("after abort");
    chk("store after abort", mem[14'h124], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
